frac_tick_gen: RTL

Multi-channel programmable tick generator producing single-cycle enable strobes from the 100 MHz system clock. Each channel has a fixed-point divisor (integer plus fractional part), so UART oversampling rates (16× baud) are held exact on average instead of truncated. Divisors are runtime-reprogrammable without glitching. Channels can be phase-aligned on demand, e.g. by the UART receiver on a start-bit edge. The block feeds the UART TX/RX oversampling enables and the slow housekeeping ticks.

---
 rtl/frac_tick_pkg.sv | 68 ++++++
 rtl/frac_tick_channel.sv | 110 +++++++++++
 rtl/frac_tick_gen.sv | 73 +++++++
 3 files changed

// File: rtl/frac_tick_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frac_tick_pkg
// Description : Shared constants for the fractional tick generator. Holds the
//               reset divisors and the 16x UART oversampling divisor table in
//               the same I.F fixed-point format as cfg_div.
// Revision    : 1.0 - initial release
// ============================================================================
package frac_tick_pkg;

  localparam int CLK_HZ = 100_000_000;
  localparam int INT_W  = 27;
  localparam int FRAC_W = 8;
  localparam int DIV_W  = INT_W + FRAC_W;

  // Reset divisors: ch0 is 16x 9600 Bd, ch1 and the rest are an 8 kHz tick.
  localparam logic [DIV_W-1:0] DIV_CH0_RST     = {27'd651,   8'd11};
  localparam logic [DIV_W-1:0] DIV_CH1_RST     = {27'd12500, 8'd0};
  localparam logic [DIV_W-1:0] DIV_DEFAULT_RST = {27'd12500, 8'd0};

  typedef enum logic [2:0] {
    BAUD_4800   = 3'd0,
    BAUD_9600   = 3'd1,
    BAUD_19200  = 3'd2,
    BAUD_38400  = 3'd3,
    BAUD_57600  = 3'd4,
    BAUD_115200 = 3'd5,
    BAUD_230400 = 3'd6,
    BAUD_460800 = 3'd7
  } baud_sel_e;

  // 16x oversampling divisors for CLK_HZ, integer part above the binary point.
  function automatic logic [DIV_W-1:0] baud_div(input baud_sel_e sel);
    logic [DIV_W-1:0] d;
    case (sel)
      BAUD_4800:   d = {27'd1302, 8'd21};
      BAUD_9600:   d = {27'd651,  8'd11};
      BAUD_19200:  d = {27'd325,  8'd133};
      BAUD_38400:  d = {27'd162,  8'd195};
      BAUD_57600:  d = {27'd108,  8'd130};
      BAUD_115200: d = {27'd54,   8'd64};
      BAUD_230400: d = {27'd27,   8'd32};
      default:     d = {27'd13,   8'd144};
    endcase
    return d;
  endfunction

  function automatic logic [DIV_W-1:0] div_rst(input int ch);
    if (ch == 0) return DIV_CH0_RST;
    if (ch == 1) return DIV_CH1_RST;
    return DIV_DEFAULT_RST;
  endfunction

  // Integer / fractional parts of a channel's reset divisor.
  function automatic int div_int_rst(input int ch);
    logic [DIV_W-1:0] d;
    d = div_rst(ch);
    return int'(d[DIV_W-1:FRAC_W]);
  endfunction

  function automatic int div_frac_rst(input int ch);
    logic [DIV_W-1:0] d;
    d = div_rst(ch);
    return int'(d[FRAC_W-1:0]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/frac_tick_channel.sv
`default_nettype none
// ============================================================================
// Module      : frac_tick_channel
// Description : One fractional tick channel. Counts I or I+1 clocks per
//               period, the extra clock chosen by the carry of a fractional
//               accumulator so the mean period equals I + F/2^FRAC_W.
//               Shadow divisor is promoted at each tick or phase restart.
// Revision    : 1.0 - initial release
// ============================================================================
module frac_tick_channel #(
  parameter int INT_W    = 27,
  parameter int FRAC_W   = 8,
  parameter int RST_INT  = 12500,
  parameter int RST_FRAC = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    en_i,
  input  logic                    sync_clr_i,
  input  logic                    wr_i,
  input  logic [INT_W+FRAC_W-1:0] wr_div_i,
  output logic                    tick_o
);

  localparam logic [INT_W-1:0]  INT_RST  = INT_W'(RST_INT);
  localparam logic [FRAC_W-1:0] FRAC_RST = FRAC_W'(RST_FRAC);

  logic [INT_W-1:0]  int_act_q,  int_act_d;
  logic [FRAC_W-1:0] frac_act_q, frac_act_d;
  logic [INT_W-1:0]  int_shd_q,  int_shd_d;
  logic [FRAC_W-1:0] frac_shd_q, frac_shd_d;
  logic [INT_W-1:0]  cnt_q,      cnt_d;
  logic [FRAC_W-1:0] acc_q,      acc_d;
  logic              ext_q,      ext_d;
  logic              tick_q,     tick_d;

  logic [INT_W-1:0]  wr_int_w;
  logic [FRAC_W-1:0] wr_frac_w;
  logic [INT_W-1:0]  last_cnt_w;
  logic              period_end_w;
  logic [FRAC_W:0]   acc_sum_w;

  assign wr_int_w   = wr_div_i[INT_W+FRAC_W-1:FRAC_W];
  assign wr_frac_w  = wr_div_i[FRAC_W-1:0];
  // Period is I_a + ext clocks; the last count is I_a + ext - 1 (I_a >= 2).
  assign last_cnt_w = int_act_q - INT_W'(1) + {{(INT_W-1){1'b0}}, ext_q};
  // ">=" rather than "==": a divisor loaded while paused may already be
  // shorter than the elapsed count, which then ends the period at once.
  assign period_end_w = (cnt_q >= last_cnt_w);
  assign acc_sum_w    = {1'b0, acc_q} + {1'b0, frac_act_q};
  assign tick_o       = tick_q;

  // Next-state: phase restart beats counting; a write in the same cycle is
  // already visible through the shadow next-state.
  always_comb begin
    int_shd_d  = wr_i ? wr_int_w  : int_shd_q;
    frac_shd_d = wr_i ? wr_frac_w : frac_shd_q;
    int_act_d  = int_act_q;
    frac_act_d = frac_act_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    ext_d      = ext_q;
    tick_d     = 1'b0;
    if (sync_clr_i) begin
      cnt_d      = '0;
      acc_d      = '0;
      ext_d      = 1'b0;
      int_act_d  = int_shd_d;
      frac_act_d = frac_shd_d;
    end else if (en_i) begin
      if (period_end_w) begin
        tick_d         = 1'b1;
        cnt_d          = '0;
        {ext_d, acc_d} = acc_sum_w;
        int_act_d      = int_shd_d;
        frac_act_d     = frac_shd_d;
      end else begin
        cnt_d = cnt_q + INT_W'(1);
      end
    end else if (wr_i) begin
      int_act_d  = wr_int_w;
      frac_act_d = wr_frac_w;
    end
  end

  // Channel state registers with asynchronous reset to the default divisor.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      int_act_q  <= INT_RST;
      frac_act_q <= FRAC_RST;
      int_shd_q  <= INT_RST;
      frac_shd_q <= FRAC_RST;
      cnt_q      <= '0;
      acc_q      <= '0;
      ext_q      <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      int_act_q  <= int_act_d;
      frac_act_q <= frac_act_d;
      int_shd_q  <= int_shd_d;
      frac_shd_q <= frac_shd_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      ext_q      <= ext_d;
      tick_q     <= tick_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/frac_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : frac_tick_gen
// Description : Multi-channel fractional tick generator. Decodes and range
//               checks divisor writes, flags rejected writes on cfg_err_o and
//               instantiates one frac_tick_channel per channel.
// Revision    : 1.0 - initial release
// ============================================================================
module frac_tick_gen #(
  parameter int N_CH   = 2,
  parameter int INT_W  = 27,
  parameter int FRAC_W = 8,
  parameter int CH_W   = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [N_CH-1:0]         en_i,
  input  logic [N_CH-1:0]         sync_clr_i,
  input  logic                    cfg_we_i,
  input  logic [CH_W-1:0]         cfg_ch_i,
  input  logic [INT_W+FRAC_W-1:0] cfg_div_i,
  output logic                    cfg_err_o,
  output logic [N_CH-1:0]         tick_o
);
  import frac_tick_pkg::*;

  localparam int               CHK_W   = CH_W + 1;
  localparam logic [INT_W-1:0] MIN_INT = INT_W'(2);

  logic [INT_W-1:0] cfg_int_w;
  logic             int_ok_w;
  logic             ch_ok_w;
  logic             wr_ok_w;
  logic             err_q, err_d;

  assign cfg_int_w = cfg_div_i[INT_W+FRAC_W-1:FRAC_W];
  assign int_ok_w  = (cfg_int_w >= MIN_INT);
  assign ch_ok_w   = ({1'b0, cfg_ch_i} < CHK_W'(N_CH));
  assign wr_ok_w   = cfg_we_i & int_ok_w & ch_ok_w;
  assign err_d     = cfg_we_i & ~(int_ok_w & ch_ok_w);
  assign cfg_err_o = err_q;

  // Rejected-write flag, registered so it pulses the cycle after the write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic ch_wr_w;
    assign ch_wr_w = wr_ok_w & (cfg_ch_i == CH_W'(g));

    frac_tick_channel #(
      .INT_W   (INT_W),
      .FRAC_W  (FRAC_W),
      .RST_INT (div_int_rst(g)),
      .RST_FRAC(div_frac_rst(g))
    ) u_chan (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .en_i      (en_i[g]),
      .sync_clr_i(sync_clr_i[g]),
      .wr_i      (ch_wr_w),
      .wr_div_i  (cfg_div_i),
      .tick_o    (tick_o[g])
    );
  end

endmodule
`default_nettype wire
